// File: rtl/pclk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// pclk_ratio_monitor
//
// Consumer-side checker for the PHY clock tree. The monitor counts
// Bit_Rate_Clk cycles between PCLK rising edges and compares each period with
// the ratio implied by DataBusWidth (8 -> 10, 16 -> 20, 32 -> 40, else 10).
// PCLK is qualified with a lock indication, a stuck-clock flag and a
// saturating count of lock-loss events.
//
// Ports:
//   Bit_Rate_Clk   in   monitor clock (bit-rate clock)
//   rst            in   asynchronous active-high reset
//   DataBusWidth   in   [5:0] configured parallel width (8/16/32)
//   PCLK_in        in   monitored PCLK (asynchronous to Bit_Rate_Clk)
//   clk_locked     out  period matched LOCK_CNT consecutive times
//   ratio_err      out  one-cycle pulse per mismatching period (TRACK/LOCKED)
//   clk_stuck      out  set on timeout, cleared on the next PCLK rising edge
//   err_count      out  [7:0] saturating count of lock-loss events
//   measured_ratio out  [7:0] last measured PCLK period in Bit_Rate_Clk cycles
// -----------------------------------------------------------------------------
module pclk_ratio_monitor #(
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 200,
    parameter int TOL      = 0
) (
    input  logic       Bit_Rate_Clk,
    input  logic       rst,
    input  logic [5:0] DataBusWidth,
    input  logic       PCLK_in,
    output logic       clk_locked,
    output logic       ratio_err,
    output logic       clk_stuck,
    output logic [7:0] err_count,
    output logic [7:0] measured_ratio
);

    localparam logic [3:0] LOCK_C    = LOCK_CNT[3:0];
    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];
    localparam logic [7:0] TOL_C     = TOL[7:0];

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state_r;
    logic       p1_r;
    logic       p2_r;
    logic [7:0] cyc_cnt_r;
    logic [3:0] match_cnt_r;
    logic [5:0] dbw_r;

    logic       rise_s;
    logic       width_chg_s;
    logic       timeout_s;
    logic       match_s;
    logic [7:0] period_s;
    logic [7:0] expected_s;
    logic [3:0] match_inc_s;

    // Ratio of bit-rate clock cycles per PCLK period for a given bus width.
    function automatic logic [7:0] expected_ratio(input logic [5:0] width);
        logic [7:0] ratio;
        case (width)
            6'd8:    ratio = 8'd10;
            6'd16:   ratio = 8'd20;
            6'd32:   ratio = 8'd40;
            default: ratio = 8'd10;
        endcase
        return ratio;
    endfunction

    // True when the measured period lies within TOL of the expected ratio.
    function automatic logic ratio_match(input logic [7:0] period,
                                         input logic [7:0] expected);
        logic [7:0] diff;
        diff = (period >= expected) ? (period - expected) : (expected - period);
        return (diff <= TOL_C);
    endfunction

    // Saturating 8-bit increment used by the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'd255) ? 8'd255 : (value + 8'd1);
    endfunction

    // Edge detection, period arithmetic and event decode.
    always_comb begin
        rise_s      = p1_r & ~p2_r;
        width_chg_s = (DataBusWidth != dbw_r);
        period_s    = (cyc_cnt_r == 8'd255) ? 8'd255 : (cyc_cnt_r + 8'd1);
        expected_s  = expected_ratio(dbw_r);
        match_s     = ratio_match(period_s, expected_s);
        // SEEK never times out: there is no lock to lose yet.
        timeout_s   = (state_r != SEEK) && (cyc_cnt_r == TIMEOUT_C);
        match_inc_s = match_cnt_r + 4'd1;
    end

    // Two-stage sampler for PCLK_in; p1 also serves as the synchroniser.
    always_ff @(posedge Bit_Rate_Clk or posedge rst) begin
        if (rst) begin
            p1_r <= 1'b0;
            p2_r <= 1'b0;
        end else begin
            p1_r <= PCLK_in;
            p2_r <= p1_r;
        end
    end

    // Period counter: restarts on every rise, otherwise saturates at 255.
    always_ff @(posedge Bit_Rate_Clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_r <= 8'd0;
        end else if (rise_s) begin
            cyc_cnt_r <= 8'd0;
        end else if (cyc_cnt_r != 8'd255) begin
            cyc_cnt_r <= cyc_cnt_r + 8'd1;
        end
    end

    // Lock FSM with all registered status outputs.
    always_ff @(posedge Bit_Rate_Clk or posedge rst) begin
        if (rst) begin
            state_r        <= SEEK;
            match_cnt_r    <= 4'd0;
            dbw_r          <= 6'd0;
            clk_locked     <= 1'b0;
            ratio_err      <= 1'b0;
            clk_stuck      <= 1'b0;
            err_count      <= 8'd0;
            measured_ratio <= 8'd0;
        end else begin
            ratio_err <= 1'b0;
            dbw_r     <= DataBusWidth;

            // Every rise reports its period and proves PCLK is toggling.
            if (rise_s) begin
                measured_ratio <= period_s;
                clk_stuck      <= 1'b0;
            end

            // A reconfiguration outranks both rise and timeout; it is not
            // counted as a lock loss.
            if (width_chg_s) begin
                state_r     <= SEEK;
                match_cnt_r <= 4'd0;
                clk_locked  <= 1'b0;
            end else if (rise_s) begin
                case (state_r)
                    SEEK: begin
                        // First edge closes a partial period: no comparison.
                        state_r     <= TRACK;
                        match_cnt_r <= 4'd0;
                    end
                    TRACK: begin
                        if (match_s) begin
                            match_cnt_r <= match_inc_s;
                            if (match_inc_s == LOCK_C) begin
                                state_r    <= LOCKED;
                                clk_locked <= 1'b1;
                            end
                        end else begin
                            match_cnt_r <= 4'd0;
                            ratio_err   <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!match_s) begin
                            state_r     <= TRACK;
                            match_cnt_r <= 4'd0;
                            clk_locked  <= 1'b0;
                            ratio_err   <= 1'b1;
                            err_count   <= sat_inc8(err_count);
                        end
                    end
                    default: begin
                        state_r     <= SEEK;
                        match_cnt_r <= 4'd0;
                        clk_locked  <= 1'b0;
                    end
                endcase
            end else if (timeout_s) begin
                state_r     <= SEEK;
                match_cnt_r <= 4'd0;
                clk_locked  <= 1'b0;
                clk_stuck   <= 1'b1;
                if (state_r == LOCKED) begin
                    err_count <= sat_inc8(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_pclk_ratio_monitor.sv
`timescale 1ns/100ps
module tb_pclk_ratio_monitor;

    logic       clk;
    logic       rst;
    logic       rst_t;
    logic [5:0] DataBusWidth;
    logic       PCLK_in;

    logic       clk_locked,   clk_locked_t;
    logic       ratio_err,    ratio_err_t;
    logic       clk_stuck,    clk_stuck_t;
    logic [7:0] err_count,    err_count_t;
    logic [7:0] measured_ratio, measured_ratio_t;

    int n_checks = 0;
    int n_errs   = 0;
    int pulses   = 0;
    int pulses_t = 0;

    pclk_ratio_monitor #(.LOCK_CNT(4), .TIMEOUT(200), .TOL(0)) dut (
        .Bit_Rate_Clk  (clk),
        .rst           (rst),
        .DataBusWidth  (DataBusWidth),
        .PCLK_in       (PCLK_in),
        .clk_locked    (clk_locked),
        .ratio_err     (ratio_err),
        .clk_stuck     (clk_stuck),
        .err_count     (err_count),
        .measured_ratio(measured_ratio)
    );

    pclk_ratio_monitor #(.LOCK_CNT(4), .TIMEOUT(200), .TOL(1)) dut_tol (
        .Bit_Rate_Clk  (clk),
        .rst           (rst_t),
        .DataBusWidth  (DataBusWidth),
        .PCLK_in       (PCLK_in),
        .clk_locked    (clk_locked_t),
        .ratio_err     (ratio_err_t),
        .clk_stuck     (clk_stuck_t),
        .err_count     (err_count_t),
        .measured_ratio(measured_ratio_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] dbw;
        int         period;
        int         nper;
        logic       exp_locked;
        int         exp_errc;
        int         exp_meas;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One Bit_Rate_Clk cycle: drive PCLK, then sample at the falling edge.
    task automatic step(input logic v);
        PCLK_in = v;
        @(negedge clk);
        if (ratio_err)   pulses++;
        if (ratio_err_t) pulses_t++;
    endtask

    task automatic run_periods(input int p, input int n);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < p; j++)
                step(j < p / 2);
    endtask

    task automatic apply_vec(input int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        DataBusWidth = vecs[i].dbw;
        pulses = 0;
        run_periods(vecs[i].period, vecs[i].nper);
        chk({tag, "_locked"}, int'(clk_locked), int'(vecs[i].exp_locked));
        chk({tag, "_errc"},   int'(err_count),  vecs[i].exp_errc);
        chk({tag, "_meas"},   int'(measured_ratio), vecs[i].exp_meas);
        chk({tag, "_pulses"}, pulses, vecs[i].exp_pulses);
        chk({tag, "_stuck"},  int'(clk_stuck), 0);
    endtask

    initial begin
        //        dbw    P  n  lock errc meas pulses
        vecs[0] = '{6'd8,  10, 5, 1'b1, 0, 10, 0};  // acquire at 8
        vecs[1] = '{6'd8,  10, 3, 1'b1, 0, 10, 0};  // steady lock
        vecs[2] = '{6'd16, 20, 5, 1'b1, 0, 20, 0};  // width change, relock
        vecs[3] = '{6'd16, 21, 1, 1'b1, 0, 20, 0};  // long period not yet measured
        vecs[4] = '{6'd16, 20, 1, 1'b0, 1, 21, 1};  // 21 measured: lock loss
        vecs[5] = '{6'd16, 20, 4, 1'b1, 1, 20, 0};  // relock after 4 periods
        vecs[6] = '{6'd32, 40, 5, 1'b1, 1, 40, 0};  // width 32 lock
        vecs[7] = '{6'd32, 40, 4, 1'b1, 2, 40, 0};  // relock after stuck clock
        vecs[8] = '{6'd8,  10, 5, 1'b1, 2, 10, 0};  // back to 8
        vecs[9] = '{6'd16, 20, 5, 1'b1, 2, 20, 0};  // relock at 16

        rst = 1'b1;
        rst_t = 1'b1;
        DataBusWidth = 6'd8;
        PCLK_in = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("rst_locked", int'(clk_locked), 0);
        chk("rst_err",    int'(ratio_err), 0);
        chk("rst_stuck",  int'(clk_stuck), 0);
        chk("rst_errc",   int'(err_count), 0);
        chk("rst_meas",   int'(measured_ratio), 0);
        rst = 1'b0;
        step(1'b0);
        step(1'b0);

        for (int i = 0; i < 7; i++) apply_vec(i);

        // Stuck clock while locked at 32: timeout lands 201 cycles after the
        // last detected rise, i.e. 163 low cycles after the 40-cycle period.
        pulses = 0;
        for (int k = 0; k < 162; k++) step(1'b0);
        chk("pre_timeout_stuck",  int'(clk_stuck), 0);
        chk("pre_timeout_locked", int'(clk_locked), 1);
        step(1'b0);
        chk("timeout_stuck",  int'(clk_stuck), 1);
        chk("timeout_locked", int'(clk_locked), 0);
        chk("timeout_errc",   int'(err_count), 2);

        // PCLK resumes: stuck clears when the first rise is seen.
        step(1'b1);
        chk("resume_stuck_hold", int'(clk_stuck), 1);
        step(1'b1);
        chk("resume_stuck_clr",  int'(clk_stuck), 0);
        for (int j = 2; j < 40; j++) step(j < 20);
        chk("resume_no_lock",   int'(clk_locked), 0);
        chk("resume_no_pulse",  pulses, 0);

        for (int i = 7; i < 9; i++) apply_vec(i);

        // Width change while locked at 8: lock drops on the next cycle.
        pulses = 0;
        DataBusWidth = 6'd16;
        step(1'b0);
        chk("wchg_locked", int'(clk_locked), 0);
        chk("wchg_pulse",  pulses, 0);
        chk("wchg_errc",   int'(err_count), 2);

        apply_vec(9);

        // Unlisted width falls back to ratio 10; compare TOL=0 and TOL=1.
        DataBusWidth = 6'd5;
        rst_t = 1'b0;
        pulses = 0;
        pulses_t = 0;
        run_periods(10, 5);
        chk("w5_locked",     int'(clk_locked), 1);
        chk("w5_locked_tol", int'(clk_locked_t), 1);
        chk("w5_meas_tol",   int'(measured_ratio_t), 10);
        run_periods(11, 1);
        run_periods(10, 1);
        chk("tol_locked",   int'(clk_locked_t), 1);
        chk("tol_pulses",   pulses_t, 0);
        chk("tol_meas",     int'(measured_ratio_t), 11);
        chk("tol_errc",     int'(err_count_t), 0);
        chk("tol0_locked",  int'(clk_locked), 0);
        chk("tol0_pulses",  pulses, 1);
        chk("tol0_errc",    int'(err_count), 3);

        // Re-lock, then assert reset between clock edges.
        run_periods(10, 5);
        chk("prerst_locked", int'(clk_locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", int'(clk_locked), 0);
        chk("arst_stuck",  int'(clk_stuck), 0);
        chk("arst_errc",   int'(err_count), 0);
        chk("arst_meas",   int'(measured_ratio), 0);
        chk("arst_err",    int'(ratio_err), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);
        step(1'b0);
        run_periods(10, 4);
        chk("reacq_not_yet", int'(clk_locked), 0);
        run_periods(10, 1);
        chk("reacq_locked",  int'(clk_locked), 1);
        chk("reacq_meas",    int'(measured_ratio), 10);
        chk("reacq_errc",    int'(err_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
